mfp_ahb_lite_master: RTL and testbench
======================================

Name: mfp_ahb_lite_master

Overview:
- AHB-Lite initiator. Converts a simple valid/ready request stream into AHB-Lite SINGLE transfers and returns one response per request, in order.
- Sits between an internal command source (debug bridge, DMA-lite engine, test sequencer) and the AHB-Lite fabric that hosts slaves such as the UART16550 wrapper.
- Pipelined: the address phase of request N+1 overlaps the data phase of request N. At most 2 transfers are outstanding.

Parameters:
- ADDR_WIDTH, 32, HADDR/req_addr width.
- DATA_WIDTH, 32, HWDATA/HRDATA/req_wdata/rsp_rdata width. Only 32 is supported.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  out  ADDR_WIDTH  address-phase address.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant 4'b0011.
- HSIZE  out  3  transfer size.
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HWDATA  out  DATA_WIDTH  data-phase write data.
- HWRITE  out  1  1 = write.
- HRDATA  in  DATA_WIDTH  read data.
- HREADY  in  1  transfer-done / wait state.
- HRESP  in  1  0 = OKAY, 1 = ERROR.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_write  in  1  1 = write.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  3  0 = byte, 1 = half, 2 = word.
- req_wdata  in  DATA_WIDTH  write data, already lane-placed.
- rsp_valid  out  1  one-cycle response pulse. The consumer has no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_error  out  1  transfer ended with ERROR, or was cancelled.

Behaviour:
- Reset (HRESET=1 at an edge): HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, and all pipeline state is cleared.
  - Reset mid-transfer drops any in-flight transfer with no response generated.
  - req_ready=0 while HRESET=1.
- Address slot (registered):
  - On an accept edge, HADDR, HWRITE, HSIZE and HTRANS=NONSEQ are driven from the next cycle.
  - They are held stable until an edge with HREADY=1.
- Write data: at the edge that ends the address phase (HREADY=1), the slot moves to the data phase and HWDATA is registered from the stored req_wdata.
- req_ready: combinational, = !HRESET && !err_first && (HTRANS==IDLE || HREADY).
- Data phase: ends at the first edge with HREADY=1.
  - rsp_valid=1 in the following cycle for exactly one cycle.
  - rsp_rdata = HRDATA captured at that edge (reads), else 0.
- Zero-wait latency: accept at edge E, address phase E..E+1, data phase E+1..E+2, rsp_valid high in cycle E+2..E+3. Each wait state adds one cycle.
- Back-to-back requests sustain one transfer per cycle with zero-wait slaves.
- HTRANS returns to IDLE after an address phase completes if no new request is accepted on that edge.
- ERROR, first cycle (HRESP=1, HREADY=0), sets err_first:
  - If a transfer is in its address phase, HTRANS is forced to IDLE on the next cycle and that request is cancelled.
  - Second cycle (HRESP=1, HREADY=1): the data-phase transfer completes with rsp_error=1 and rsp_rdata=0.
  - The cancelled request then produces its own rsp_valid with rsp_error=1 one cycle later. Order is preserved and there is no retry.
- HRESP=1 together with HREADY=1 with no preceding first cycle (protocol violation): treated as an error completion. No cancellation is applied.
- req_size > 2: forced to 2.

Optional Feature:
- MFP_AHB_MASTER_ALIGN_CHECK_EN defined: a misaligned request (half with addr[0]=1, word with addr[1:0]!=0) is accepted but never put on the bus.
  - It yields rsp_valid with rsp_error=1 one cycle after the responses of all older requests.
  - HTRANS stays IDLE for it.
- Undefined: the address is driven unmodified and alignment is the slave's concern.

Decomposition:
- Package mfp_ahb_lite_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ.
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD.
  - HBURST_SINGLE.
  - HRESP_OKAY and HRESP_ERROR.
  - HPROT_DEFAULT.
- Single module; no sub-module. The address-slot and data-slot registers are inline.

Test Plan:
- Reset while HTRANS=NONSEQ with HREADY=0 -> next cycle HTRANS=0, rsp_valid never asserts, req_ready=1 after HRESET drops.
- Write 0x1000_0004 with data 0xDEADBEEF, size 2, zero-wait slave -> HADDR=0x10000004 and HWRITE=1 one cycle after accept; HWDATA=0xDEADBEEF next cycle; rsp_valid with rsp_error=0 one cycle later.
- Read with 3 wait states, HRDATA=0x12345678 -> HADDR held 4 cycles, rsp_rdata=0x12345678, rsp_error=0.
- Four back-to-back reads to 0x0/0x4/0x8/0xC, zero-wait -> HTRANS=NONSEQ for 4 consecutive cycles, 4 in-order rsp_valid pulses on consecutive cycles.
- Two-cycle ERROR on a write while a read is pipelined -> HTRANS=IDLE in the second error cycle, two responses both with rsp_error=1, read never reissued.
- With MFP_AHB_MASTER_ALIGN_CHECK_EN, word read at 0x2 -> HTRANS stays 0, rsp_error=1 one cycle after accept.

Source files
------------

// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the mfp AHB-Lite initiator, plus the
// request-size clamp and alignment helpers used by the master.
package mfp_ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Sizes above a word cannot be carried on a 32-bit bus.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > HSIZE_WORD) ? HSIZE_WORD : size;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        return ((size == HSIZE_HALF) && addr_lo[0]) ||
               ((size == HSIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: valid/ready requests become pipelined SINGLE transfers,
// one in-order response each. Optional MFP_AHB_MASTER_ALIGN_CHECK_EN rejects misaligned requests locally.
module mfp_ahb_lite_master
    import mfp_ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic                  HMASTLOCK,
    output logic [3:0]            HPROT,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error
);

    logic                  a_vld_q, a_vld_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic                  a_write_q, a_write_d;
    logic [2:0]            a_size_q, a_size_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    logic                  d_vld_q, d_vld_d;
    logic                  d_write_q, d_write_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic                  err_first_q, err_first_d;
    logic                  cxl_q, cxl_d;
    logic                  mis_q, mis_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic       accept;
    logic       misalign;
    logic       mis_block;
    logic [2:0] req_size_c;

    assign req_size_c = clamp_size(req_size);

`ifdef MFP_AHB_MASTER_ALIGN_CHECK_EN
    assign misalign  = misaligned(req_size_c, req_addr[1:0]);
    // A pending local rejection must answer before anything newer is taken.
    assign mis_block = mis_q;
`else
    assign misalign  = 1'b0;
    assign mis_block = 1'b0;
`endif

    assign req_ready = !HRESET && !err_first_q && !mis_block && (!a_vld_q || HREADY);
    assign accept    = req_valid && req_ready;

    always_comb begin
        a_vld_d     = a_vld_q;
        a_addr_d    = a_addr_q;
        a_write_d   = a_write_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        d_vld_d     = d_vld_q;
        d_write_d   = d_write_q;
        hwdata_d    = hwdata_q;
        err_first_d = err_first_q;
        cxl_d       = cxl_q;
        mis_d       = mis_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;

        if (HREADY) begin
            if (d_vld_q) begin
                rsp_valid_d = 1'b1;
                rsp_error_d = HRESP;
                rsp_rdata_d = (!d_write_q && (HRESP == HRESP_OKAY)) ? HRDATA : '0;
            end
            d_vld_d = a_vld_q;
            if (a_vld_q) begin
                d_write_d = a_write_q;
                hwdata_d  = a_wdata_q;
            end
            a_vld_d     = 1'b0;
            err_first_d = 1'b0;
        end else if (d_vld_q && (HRESP == HRESP_ERROR)) begin
            // First ERROR cycle: withdraw the pipelined address phase, answer it later.
            err_first_d = 1'b1;
            if (a_vld_q) begin
                a_vld_d = 1'b0;
                cxl_d   = 1'b1;
            end
        end

        if (cxl_q && !err_first_q) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            cxl_d       = 1'b0;
        end

        if (mis_q && !a_vld_q && !d_vld_q && !cxl_q) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            mis_d       = 1'b0;
        end

        if (accept) begin
            if (misalign) begin
                mis_d = 1'b1;
            end else begin
                a_vld_d   = 1'b1;
                a_addr_d  = req_addr;
                a_write_d = req_write;
                a_size_d  = req_size_c;
                a_wdata_d = req_wdata;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld_q     <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= HSIZE_BYTE;
            a_wdata_q   <= '0;
            d_vld_q     <= 1'b0;
            d_write_q   <= 1'b0;
            hwdata_q    <= '0;
            err_first_q <= 1'b0;
            cxl_q       <= 1'b0;
            mis_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_vld_q     <= a_vld_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            d_vld_q     <= d_vld_d;
            d_write_q   <= d_write_d;
            hwdata_q    <= hwdata_d;
            err_first_q <= err_first_d;
            cxl_q       <= cxl_d;
            mis_q       <= mis_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = a_size_q;
    assign HTRANS    = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_DEFAULT;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master: scripted slave handshake, read data
// derived from the data-phase address, responses scored against an expected queue.
module tb_mfp_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int rsp_cnt = 0;
    int n_push  = 0;
    logic [32:0] exp_q[$];
    logic [31:0] dp_addr = 32'h0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return 32'h1234_5678 ^ (a << 4);
    endfunction

    // Slave: latch the address at the end of each address phase, serve data from it.
    always @(posedge HCLK) if (HREADY) dp_addr <= HADDR;
    assign HRDATA = rd(dp_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [32:0] e;
        @(negedge HCLK);
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_error", 32'(rsp_error), 32'(e[32]));
                chk("rsp_rdata", rsp_rdata, e[31:0]);
            end
        end
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit push, input logic perr,
                        input logic [31:0] prd, input bit onbus);
        int k;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wd;
        #1;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            tick();
            #1;
            k++;
        end
        if (req_ready !== 1'b1) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            if (push) begin
                exp_q.push_back({perr, prd});
                n_push++;
            end
            tick();
            req_valid = 1'b0;
            if (onbus) begin
                chk("addr_htrans", 32'(HTRANS), 32'h2);
                chk("addr_haddr", HADDR, a);
                chk("addr_hwrite", 32'(HWRITE), 32'(wr));
                chk("addr_hsize", 32'(HSIZE), (sz > 3'd2) ? 32'd2 : 32'(sz));
            end else begin
                chk("misalign_htrans", 32'(HTRANS), 32'h0);
            end
        end
    endtask

    initial begin
        int base;
        HRESET    = 1'b1;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'd0;
        req_wdata = 32'h0;

        tick();
        tick();
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("const_hburst", 32'(HBURST), 32'h0);
        chk("const_hprot", 32'(HPROT), 32'h3);
        chk("const_hmastlock", 32'(HMASTLOCK), 32'h0);
        HRESET = 1'b0;
        tick();

        // Reset while an address phase is stalled: transfer vanishes silently.
        HREADY = 1'b0;
        base = rsp_cnt;
        send(1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        HRESET = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("midrst_htrans", 32'(HTRANS), 32'h0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        HRESET = 1'b0;
        HREADY = 1'b1;
        #1;
        chk("midrst_req_ready_after", 32'(req_ready), 32'h1);
        repeat (4) tick();
        chk("midrst_no_rsp", 32'(rsp_cnt - base), 32'd0);

        // Zero-wait word write.
        send(1'b1, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("wr_htrans_idle", 32'(HTRANS), 32'h0);
        chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        tick();
        chk("wr_rsp_one_cycle", 32'(rsp_valid), 32'h0);

        // Read with three data-phase wait states.
        send(1'b0, 32'h0, 3'd2, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("wait_haddr", HADDR, 32'h0);
        end
        HREADY = 1'b1;
        tick();
        chk("wait_rsp_valid_end", 32'(rsp_valid), 32'h1);
        tick();

        // Byte write and an oversized read that must be clamped to a word.
        send(1'b1, 32'h2001, 3'd0, 32'h0000_AB00, 1'b1, 1'b0, 32'h0, 1'b1);
        send(1'b0, 32'h30, 3'd7, 32'h0, 1'b1, 1'b0, rd(32'h30), 1'b1);
        repeat (3) tick();

        // Four back-to-back zero-wait reads.
        base = rsp_cnt;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'(i * 4), 3'd2, 32'h0, 1'b1, 1'b0, rd(32'(i * 4)), 1'b1);
        end
        tick();
        chk("b2b_rsp3", 32'(rsp_valid), 32'h1);
        tick();
        chk("b2b_rsp4", 32'(rsp_valid), 32'h1);
        chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd4);
        tick();
        chk("b2b_rsp_end", 32'(rsp_valid), 32'h0);

        // Two-cycle ERROR on a write with a read in its address phase.
        send(1'b1, 32'h20, 3'd2, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0, 1'b1);
        send(1'b0, 32'h24, 3'd2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();
        chk("err_htrans_idle", 32'(HTRANS), 32'h0);
        #1;
        chk("err_req_ready", 32'(req_ready), 32'h0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("err_rsp1_valid", 32'(rsp_valid), 32'h1);
        chk("err_no_reissue1", 32'(HTRANS), 32'h0);
        tick();
        chk("err_rsp2_valid", 32'(rsp_valid), 32'h1);
        chk("err_no_reissue2", 32'(HTRANS), 32'h0);
        tick();

        // ERROR without a first cycle: error completion, follower not cancelled.
        send(1'b0, 32'h50, 3'd2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        send(1'b0, 32'h54, 3'd2, 32'h0, 1'b1, 1'b0, rd(32'h54), 1'b1);
        HRESP = 1'b1;
        tick();
        HRESP = 1'b0;
        tick();
        chk("viol_follower_rsp", 32'(rsp_valid), 32'h1);
        tick();

`ifdef MFP_AHB_MASTER_ALIGN_CHECK_EN
        send(1'b0, 32'h2, 3'd2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
        tick();
        chk("misalign_rsp", 32'(rsp_valid), 32'h1);
        chk("misalign_htrans_after", 32'(HTRANS), 32'h0);
        tick();
`endif

        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("rsp_total", 32'(rsp_cnt), 32'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
